// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg: the master drives the op request and
// serial/parallel data, the slave returns the registered shift state and handshake.
interface univ_shift_reg_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             clr;
  logic             en;
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic             d;
  logic [WIDTH-1:0] pdata;
  logic [WIDTH-1:0] out;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output clr, en, start, mode, amt, d, pdata,
    input  out, sout, busy, done
  );

  modport slave (
    input  clr, en, start, mode, amt, d, pdata,
    output out, sout, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: one op per clock, either single-step or an amt-long
// burst; all outputs registered, request inputs are ignored while a burst runs.
module univ_shift_reg #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input logic              clk,
  input logic              rstn,
  univ_shift_reg_if.slave  bus
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] out_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;

  // Returns {sout, out} after one op; hold/load/reserved keep sout.
  function automatic logic [WIDTH:0] step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             sin,
    input logic             so,
    input logic [WIDTH-1:0] pd
  );
    logic [WIDTH:0] r;
    r = {so, v};
    case (m)
      M_SHL:   r = {v[WIDTH-1], v[WIDTH-2:0], sin};
      M_SHR:   r = {v[0], sin, v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   r = {v[0], v[0], v[WIDTH-1:1]};
      M_ASR:   r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      M_LOAD:  r = {so, pd};
      M_HOLD:  r = {so, v};
      default: r = {so, v};
    endcase
    return r;
  endfunction

  logic burst_req;
  assign burst_req = (bus.amt != '0) && (bus.mode >= M_SHL) && (bus.mode <= M_ASR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      mode_q <= M_HOLD;
      cnt    <= '0;
      out_q  <= '0;
      sout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr) begin
            out_q  <= '0;
            sout_q <= 1'b0;
          end else if (bus.start) begin
            if (burst_req) begin
              mode_q <= bus.mode;
              cnt    <= bus.amt;
              busy_q <= 1'b1;
              state  <= BUSY;
            end else begin
              // Zero-length or non-shift start degenerates to a single op.
              {sout_q, out_q} <= step(bus.mode, out_q, bus.d, sout_q, bus.pdata);
              done_q          <= 1'b1;
            end
          end else if (bus.en) begin
            {sout_q, out_q} <= step(bus.mode, out_q, bus.d, sout_q, bus.pdata);
          end
        end
        BUSY: begin
          if (bus.clr) begin
            out_q  <= '0;
            sout_q <= 1'b0;
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            {sout_q, out_q} <= step(mode_q, out_q, bus.d, sout_q, bus.pdata);
            cnt             <= cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: vector table, hand-written burst/abort sequences,
// then random traffic against an arithmetic reference model.
module tb_univ_shift_reg;
  localparam int W  = 16;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(W), .AMT_W(AW)) bus();
  univ_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: register value as an integer, burst as ops remaining.
  logic [W-1:0] m_out;
  logic         m_sout, m_busy, m_done;
  logic [2:0]   m_mode;
  int           m_rem;

  task automatic model_op(input logic [2:0] m, input logic sin, input logic [W-1:0] pd);
    int unsigned v, nv, ns, msb;
    v   = m_out;
    msb = 1 << (W - 1);
    nv  = v;
    ns  = m_sout;
    case (m)
      3'd1: begin nv = ((v * 2) + sin) % (1 << W); ns = v / msb; end
      3'd2: begin nv = (v / 2) + (sin ? msb : 0);   ns = v % 2; end
      3'd3: begin nv = ((v * 2) % (1 << W)) + v / msb; ns = v / msb; end
      3'd4: begin nv = (v / 2) + ((v % 2) * msb);   ns = v % 2; end
      3'd5: begin nv = (v / 2) + (v & msb);         ns = v % 2; end
      3'd6: nv = pd;
      default: ;
    endcase
    m_out  = nv[W-1:0];
    m_sout = ns[0];
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_out = '0; m_sout = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (bus.clr) begin
          m_out = '0; m_sout = 0;
        end else if (bus.start) begin
          if (bus.amt != 0 && bus.mode >= 1 && bus.mode <= 5) begin
            m_mode = bus.mode; m_rem = bus.amt; m_busy = 1;
          end else begin
            model_op(bus.mode, bus.d, bus.pdata);
            m_done = 1;
          end
        end else if (bus.en) begin
          model_op(bus.mode, bus.d, bus.pdata);
        end
      end else if (bus.clr) begin
        m_out = '0; m_sout = 0; m_busy = 0; m_rem = 0;
      end else begin
        model_op(m_mode, bus.d, bus.pdata);
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out"},  32'(bus.out),  32'(m_out));
    chk({tag, ".sout"}, 32'(bus.sout), 32'(m_sout));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
  endtask

  task automatic drv(input logic c, input logic e, input logic s, input logic [2:0] m,
                     input logic [AW-1:0] a, input logic dd, input logic [W-1:0] pd);
    bus.clr = c; bus.en = e; bus.start = s; bus.mode = m; bus.amt = a; bus.d = dd; bus.pdata = pd;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_burst(input logic [2:0] m, input logic [AW-1:0] a, input logic dd,
                           input logic en_too, input logic noise, output int nb, output bit gd);
    drv(0, en_too, 1, m, a, dd, '0);
    tick();
    bus.start = 0; bus.en = 0;
    chk_model("burst.accept");
    nb = 0;
    gd = 0;
    for (int i = 0; i < 64; i++) begin
      if (bus.done) begin gd = 1; break; end
      if (bus.busy) nb++;
      if (noise) begin
        bus.mode = 3'($urandom_range(0, 7)); bus.en = 1'($urandom);
        bus.start = 1'($urandom); bus.pdata = 16'($urandom); bus.amt = 5'($urandom);
      end
      tick();
      chk_model("burst.run");
    end
    bus.start = 0; bus.en = 0;
  endtask

  typedef struct {
    logic clr, en, start; logic [2:0] mode; logic [AW-1:0] amt; logic d; logic [W-1:0] pdata;
    logic [W-1:0] eo; logic es, eb, ed;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic c, input logic e, input logic s, input logic [2:0] m,
                     input logic [AW-1:0] a, input logic dd, input logic [W-1:0] pd,
                     input logic [W-1:0] eo, input logic es, input logic eb, input logic ed);
    vec_t v;
    v.clr = c; v.en = e; v.start = s; v.mode = m; v.amt = a; v.d = dd; v.pdata = pd;
    v.eo = eo; v.es = es; v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endtask

  int  nb;
  bit  gd;

  initial begin
    //   clr en st mode   amt d pdata     out      sout busy done
    add(0, 1, 0, 3'd6, 0, 0, 16'hA5C3, 16'hA5C3, 0, 0, 0);
    add(0, 1, 0, 3'd6, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
    add(0, 1, 0, 3'd1, 0, 1, 16'h0000, 16'h0003, 0, 0, 0);
    add(0, 1, 0, 3'd1, 0, 1, 16'h0000, 16'h0007, 0, 0, 0);
    add(0, 1, 0, 3'd1, 0, 1, 16'h0000, 16'h000F, 0, 0, 0);
    add(0, 1, 0, 3'd2, 0, 0, 16'h0000, 16'h0007, 1, 0, 0);
    add(0, 1, 0, 3'd0, 0, 0, 16'hFFFF, 16'h0007, 1, 0, 0);
    add(0, 1, 0, 3'd7, 0, 1, 16'hFFFF, 16'h0007, 1, 0, 0);
    add(0, 1, 0, 3'd6, 0, 0, 16'h8001, 16'h8001, 1, 0, 0);
    add(0, 0, 1, 3'd3, 4, 0, 16'h0000, 16'h8001, 1, 1, 0);
    add(0, 0, 0, 3'd0, 0, 0, 16'h0000, 16'h0003, 1, 1, 0);
    add(0, 0, 0, 3'd0, 0, 0, 16'h0000, 16'h0006, 0, 1, 0);
    add(0, 0, 0, 3'd0, 0, 0, 16'h0000, 16'h000C, 0, 1, 0);
    add(0, 0, 0, 3'd0, 0, 0, 16'h0000, 16'h0018, 0, 0, 1);
    add(0, 0, 0, 3'd0, 0, 0, 16'h0000, 16'h0018, 0, 0, 0);
    add(0, 0, 1, 3'd0, 0, 0, 16'h0000, 16'h0018, 0, 0, 1);
    add(0, 0, 1, 3'd1, 0, 1, 16'h0000, 16'h0031, 0, 0, 1);
    add(0, 0, 1, 3'd6, 5, 0, 16'h1234, 16'h1234, 0, 0, 1);
    add(0, 0, 0, 3'd0, 0, 0, 16'h0000, 16'h1234, 0, 0, 0);
    add(1, 1, 1, 3'd3, 4, 1, 16'hFFFF, 16'h0000, 0, 0, 0);

    rstn = 0;
    drv(0, 0, 0, 0, 0, 0, '0);
    #1;
    chk("rst.out", 32'(bus.out), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    tick(); tick();
    rstn = 1;
    tick();
    chk("rst.exit.done", 32'(bus.done), 0);
    chk("rst.exit.sout", 32'(bus.sout), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drv(vecs[i].clr, vecs[i].en, vecs[i].start, vecs[i].mode, vecs[i].amt, vecs[i].d, vecs[i].pdata);
      tick();
      chk($sformatf("vec%0d.out", i),  32'(bus.out),  32'(vecs[i].eo));
      chk($sformatf("vec%0d.sout", i), 32'(bus.sout), 32'(vecs[i].es));
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].eb));
      chk($sformatf("vec%0d.done", i), 32'(bus.done), 32'(vecs[i].ed));
    end

    // Full-width rotate returns the original value.
    drv(0, 1, 0, 3'd6, 0, 0, 16'h8001); tick();
    run_burst(3'd3, 16, 0, 0, 0, nb, gd);
    chk("rol16.done", 32'(gd), 1);
    chk("rol16.busy_cycles", nb, 16);
    chk("rol16.out", 32'(bus.out), 32'h8001);

    // ASR with request inputs toggling during the burst.
    drv(0, 1, 0, 3'd6, 0, 0, 16'h8000); tick();
    run_burst(3'd5, 3, 0, 0, 1, nb, gd);
    chk("asr3.done", 32'(gd), 1);
    chk("asr3.busy_cycles", nb, 3);
    chk("asr3.out", 32'(bus.out), 32'hF000);

    // start with en: only the burst happens.
    run_burst(3'd1, 2, 1, 1, 0, nb, gd);
    chk("start_en.busy_cycles", nb, 2);
    chk("start_en.out", 32'(bus.out), 32'hC003);

    // New start accepted in the done cycle.
    run_burst(3'd4, 1, 0, 0, 0, nb, gd);
    chk("back2back.done", 32'(gd), 1);
    chk("back2back.busy_cycles", nb, 1);
    chk("back2back.out", 32'(bus.out), 32'hE001);
    chk("back2back.sout", 32'(bus.sout), 1);
    tick();
    chk("back2back.done_clears", 32'(bus.done), 0);

    // clr in the second busy cycle aborts without done.
    drv(0, 1, 0, 3'd6, 0, 0, 16'h00FF); tick();
    drv(0, 0, 1, 3'd1, 8, 1, '0); tick();
    drv(0, 0, 0, 3'd0, 0, 1, '0); tick();
    chk("abort.busy_mid", 32'(bus.busy), 1);
    bus.clr = 1; tick(); bus.clr = 0;
    chk("abort.out", 32'(bus.out), 0);
    chk("abort.busy", 32'(bus.busy), 0);
    chk("abort.done", 32'(bus.done), 0);
    tick();
    chk("abort.no_done", 32'(bus.done), 0);
    chk_model("abort.model");

    // Asynchronous reset mid-burst, then a normal burst.
    drv(0, 1, 0, 3'd6, 0, 0, 16'h1234); tick();
    drv(0, 0, 1, 3'd3, 8, 0, '0); tick();
    drv(0, 0, 0, 3'd0, 0, 0, '0); tick();
    #2 rstn = 0;
    #1;
    chk("arst.out", 32'(bus.out), 0);
    chk("arst.busy", 32'(bus.busy), 0);
    chk("arst.done", 32'(bus.done), 0);
    tick();
    rstn = 1;
    tick();
    chk("arst.exit.done", 32'(bus.done), 0);
    drv(0, 1, 0, 3'd6, 0, 0, 16'h0F0F); tick();
    run_burst(3'd3, 4, 0, 0, 0, nb, gd);
    chk("arst.burst.done", 32'(gd), 1);
    chk("arst.burst.busy_cycles", nb, 4);
    chk("arst.burst.out", 32'(bus.out), 32'hF0F0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drv(1'($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom_range(0, 5) == 0),
          3'($urandom_range(0, 7)), 5'($urandom_range(0, 20)), 1'($urandom), 16'($urandom));
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
